// File: rtl/vend_arbiter.sv
// Round-robin arbiter sharing one vending core (price 15, coins 5/10) among N coin lanes.
// Define FIXED_PRIO_EN to always grant the lowest-index requester instead of round-robin.
module vend_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [2*N-1:0] coin,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [1:0]     chg,
  output logic [N-1:0]   refund,
  output logic [1:0]     refund_amt,
  output logic           busy,
  output logic           fault,
  output logic [1:0]     core_in,
  output logic           core_clr,
  input  logic           core_out,
  input  logic [1:0]     core_change
);

  localparam int GW = (N > 2) ? 2 : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ACTIVE, S_VEND_WAIT, S_ABORT, S_RELEASE
  } state_t;

  state_t        state_q;
  logic [N-1:0]  gnt_q;
  logic [GW-1:0] g_q;
  logic [1:0]    credit_q;   // credit in units of 5: 0, 1 or 2
  logic [TW-1:0] timer_q;
  logic          fault_q;
  logic          core_clr_q;

  logic [GW-1:0] pick_d;
  logic [1:0]    lane_coin;
  logic [2:0]    sum;
  logic          dispense;

`ifndef FIXED_PRIO_EN
  logic [GW-1:0] rr_q;
  logic          found;
  int            idx;
`endif

  always_comb begin
    pick_d = '0;
`ifdef FIXED_PRIO_EN
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) pick_d = GW'(k);
    end
`else
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_q) + k) % N;
      if (!found && req[idx]) begin
        found  = 1'b1;
        pick_d = GW'(idx);
      end
    end
`endif
  end

  // Illegal code 11 is treated as no coin
  always_comb begin
    lane_coin = coin[int'(g_q)*2 +: 2];
    if (lane_coin == 2'b11) lane_coin = 2'b00;
  end

  assign sum      = {1'b0, credit_q} + {1'b0, lane_coin};
  assign dispense = core_out && ((state_q == S_ACTIVE) || (state_q == S_VEND_WAIT));

  assign core_in    = (state_q == S_ACTIVE) ? lane_coin : 2'b00;
  assign gnt        = gnt_q;
  assign done       = dispense ? gnt_q : '0;
  assign chg        = dispense ? core_change : 2'b00;
  assign refund     = (state_q == S_ABORT) ? (N'(1) << g_q) : '0;
  assign refund_amt = (state_q == S_ABORT) ? credit_q : 2'b00;
  assign busy       = (state_q != S_IDLE);
  assign fault      = fault_q;
  assign core_clr   = core_clr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      g_q        <= '0;
      credit_q   <= 2'd0;
      timer_q    <= '0;
      fault_q    <= 1'b0;
      core_clr_q <= 1'b0;
`ifndef FIXED_PRIO_EN
      rr_q       <= '0;
`endif
    end else begin
      core_clr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            g_q      <= pick_d;
            gnt_q    <= N'(1) << pick_d;
            credit_q <= 2'd0;
            timer_q  <= '0;
            state_q  <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (core_out) begin
            credit_q <= 2'd0;
            gnt_q    <= '0;
            state_q  <= S_RELEASE;
          end else if (lane_coin != 2'b00) begin
            timer_q <= '0;
            if (sum >= 3'd3) begin
              credit_q <= 2'd0;
              state_q  <= S_VEND_WAIT;
            end else begin
              credit_q <= sum[1:0];
            end
          end else if (!req[g_q] && credit_q == 2'd0) begin
            gnt_q   <= '0;
            state_q <= S_RELEASE;
          end else if (timer_q == TW'(TIMEOUT)) begin
            if (credit_q == 2'd0) begin
              gnt_q   <= '0;
              state_q <= S_RELEASE;
            end else begin
              core_clr_q <= 1'b1;
              state_q    <= S_ABORT;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_VEND_WAIT: begin
          if (core_out) begin
            gnt_q   <= '0;
            state_q <= S_RELEASE;
          end else if (timer_q == TW'(TIMEOUT)) begin
            fault_q    <= 1'b1;
            core_clr_q <= 1'b1;
            gnt_q      <= '0;
            state_q    <= S_RELEASE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_ABORT: begin
          credit_q <= 2'd0;
          gnt_q    <= '0;
          state_q  <= S_RELEASE;
        end
        S_RELEASE: begin
`ifndef FIXED_PRIO_EN
          rr_q    <= GW'((int'(g_q) + 1) % N);
`endif
          timer_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_arbiter.sv
// Self-checking bench for vend_arbiter: directed table, hand sequences and randomized traffic vs. a money-level model.
module tb_vend_arbiter;
  localparam int N = 2, TIMEOUT = 16, TW = 5;
  localparam int P_IDLE = 0, P_ACTIVE = 1, P_WAIT = 2, P_ABORT = 3, P_RELEASE = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req;
  logic [2*N-1:0] coin;
  logic core_out;
  logic [1:0] core_change;
  logic [N-1:0] gnt, done, refund;
  logic [1:0] chg, refund_amt, core_in;
  logic busy, fault, core_clr;

  vend_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rst(rst), .req(req), .coin(coin), .gnt(gnt), .done(done), .chg(chg),
    .refund(refund), .refund_amt(refund_amt), .busy(busy), .fault(fault), .core_in(core_in),
    .core_clr(core_clr), .core_out(core_out), .core_change(core_change));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Reference model: who holds the machine, how much money is in, how long it has been idle
  int m_phase, m_lane, m_credit, m_idle, m_rr, m_fault, m_clr;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cents(input logic [1:0] c);
    if (c == 2'b01) return 5;
    if (c == 2'b10) return 10;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_lane = 0; m_credit = 0; m_idle = 0; m_rr = 0; m_fault = 0; m_clr = 0;
  endtask

  task automatic check_model();
    int v, holding, disp;
    logic [1:0] lc;
    lc = coin[2*m_lane +: 2];
    v = cents(lc);
    holding = (m_phase == P_ACTIVE || m_phase == P_WAIT || m_phase == P_ABORT);
    disp = core_out && (m_phase == P_ACTIVE || m_phase == P_WAIT);
    chk("gnt", int'(gnt), holding ? (1 << m_lane) : 0);
    chk("busy", int'(busy), m_phase != P_IDLE);
    chk("core_in", int'(core_in), (m_phase == P_ACTIVE) ? v / 5 : 0);
    chk("done", int'(done), disp ? (1 << m_lane) : 0);
    chk("chg", int'(chg), disp ? int'(core_change) : 0);
    chk("refund", int'(refund), (m_phase == P_ABORT) ? (1 << m_lane) : 0);
    chk("refund_amt", int'(refund_amt), (m_phase == P_ABORT) ? m_credit / 5 : 0);
    chk("core_clr", int'(core_clr), m_clr);
    chk("fault", int'(fault), m_fault);
  endtask

  task automatic model_next();
    int v, nclr;
    v = cents(coin[2*m_lane +: 2]);
    nclr = 0;
    case (m_phase)
      P_IDLE: if (req != 0) begin
`ifdef FIXED_PRIO_EN
        for (int k = N - 1; k >= 0; k--) if (req[k]) m_lane = k;
`else
        for (int k = N - 1; k >= 0; k--) if (req[(m_rr + k) % N]) m_lane = (m_rr + k) % N;
`endif
        m_credit = 0; m_idle = 0; m_phase = P_ACTIVE;
      end
      P_ACTIVE: begin
        if (core_out) m_phase = P_RELEASE;
        else if (v > 0) begin
          m_idle = 0;
          if (m_credit + v >= 15) m_phase = P_WAIT;
          else m_credit += v;
        end else if (!req[m_lane] && m_credit == 0) m_phase = P_RELEASE;
        else if (m_idle == TIMEOUT) begin
          if (m_credit == 0) m_phase = P_RELEASE;
          else begin m_phase = P_ABORT; nclr = 1; end
        end else m_idle++;
      end
      P_WAIT: begin
        if (core_out) m_phase = P_RELEASE;
        else if (m_idle == TIMEOUT) begin m_fault = 1; nclr = 1; m_phase = P_RELEASE; end
        else m_idle++;
      end
      P_ABORT: begin m_credit = 0; m_phase = P_RELEASE; end
      default: begin m_rr = (m_lane + 1) % N; m_phase = P_IDLE; end
    endcase
    m_clr = nclr;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [2*N-1:0] c, input logic co,
                       input logic [1:0] cc);
    @(negedge clk);
    req = r; coin = c; core_out = co; core_change = cc;
    #1;
    check_model();
    model_next();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = '0; coin = '0; core_out = 1'b0; core_change = 2'b00;
    model_reset();
    @(negedge clk);
    #1;
    check_model();
    rst = 1'b1;
  endtask

  typedef struct {
    logic [1:0] r; logic [3:0] c; logic co; logic [1:0] cc;
    logic [1:0] e_gnt; logic [1:0] e_done; logic [1:0] e_chg; logic e_busy; logic [1:0] e_cin;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int exp_l, seen, at;
    logic [3:0] cv;

    tbl[0] = '{2'b01, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00};
    tbl[1] = '{2'b01, 4'b0010, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 2'b10};
    tbl[2] = '{2'b01, 4'b0001, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01};
    tbl[3] = '{2'b01, 4'b0000, 1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1, 2'b00};
    tbl[4] = '{2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00};
    tbl[5] = '{2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00};

    rst = 1'b0; req = '0; coin = '0; core_out = 1'b0; core_change = 2'b00;
    model_reset();
    #12;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_clr", int'(core_clr), 0);
    do_reset();

    // Single lane vend: 10 then 5, dispense with no change
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].r, tbl[i].c, tbl[i].co, tbl[i].cc);
      chk($sformatf("t1_gnt[%0d]", i), int'(gnt), int'(tbl[i].e_gnt));
      chk($sformatf("t1_done[%0d]", i), int'(done), int'(tbl[i].e_done));
      chk($sformatf("t1_chg[%0d]", i), int'(chg), int'(tbl[i].e_chg));
      chk($sformatf("t1_busy[%0d]", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("t1_core_in[%0d]", i), int'(core_in), int'(tbl[i].e_cin));
    end

    // Both lanes requesting: grants alternate (or stick to lane 0 with fixed priority)
    do_reset();
    for (int t = 0; t < 3; t++) begin
`ifdef FIXED_PRIO_EN
      exp_l = 0;
`else
      exp_l = t % 2;
`endif
      cv = 4'b0010 << (2 * exp_l);
      drive(2'b11, 4'b0000, 1'b0, 2'b00);
      drive(2'b11, cv, 1'b0, 2'b00);
      chk($sformatf("t2_gnt[%0d]", t), int'(gnt), 1 << exp_l);
      drive(2'b11, cv, 1'b0, 2'b00);
      drive(2'b11, 4'b0000, 1'b1, 2'b01);
      chk($sformatf("t2_done[%0d]", t), int'(done), 1 << exp_l);
      chk($sformatf("t2_chg[%0d]", t), int'(chg), 1);
      drive(2'b11, 4'b0000, 1'b0, 2'b00);
      chk($sformatf("t2_rel_gnt[%0d]", t), int'(gnt), 0);
    end

    // Lane 1 pays 5 then goes quiet: abort with refund of 5
    do_reset();
    drive(2'b10, 4'b0000, 1'b0, 2'b00);
    drive(2'b10, 4'b0100, 1'b0, 2'b00);
    chk("t3_gnt", int'(gnt), 2);
    chk("t3_core_in", int'(core_in), 1);
    seen = 0; at = -1;
    for (int i = 0; i < 60 && !seen; i++) begin
      drive(2'b10, 4'b0000, 1'b0, 2'b00);
      if (refund != 0) begin
        seen = 1; at = i;
        chk("t3_refund", int'(refund), 2);
        chk("t3_refund_amt", int'(refund_amt), 1);
        chk("t3_core_clr", int'(core_clr), 1);
      end
    end
    chk("t3_refund_seen", seen, 1);
    chk("t3_refund_cycle", at, TIMEOUT + 1);
    drive(2'b10, 4'b0000, 1'b0, 2'b00);
    chk("t3_gnt_after", int'(gnt), 0);

    // Vend reached but the core never dispenses: sticky fault
    do_reset();
    drive(2'b01, 4'b0000, 1'b0, 2'b00);
    drive(2'b01, 4'b0010, 1'b0, 2'b00);
    drive(2'b01, 4'b0010, 1'b0, 2'b00);
    seen = 0; at = -1;
    for (int i = 0; i < 60 && !seen; i++) begin
      drive(2'b01, 4'b0000, 1'b0, 2'b00);
      chk("t4_no_refund", int'(refund), 0);
      chk("t4_no_done", int'(done), 0);
      if (fault) begin
        seen = 1; at = i;
        chk("t4_core_clr", int'(core_clr), 1);
        chk("t4_gnt", int'(gnt), 0);
      end
    end
    chk("t4_fault_seen", seen, 1);
    chk("t4_fault_cycle", at, TIMEOUT + 1);
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, 4'b0000, 1'b0, 2'b00);
      chk("t4_fault_sticky", int'(fault), 1);
    end

    // Foreign-lane coins ignored, then asynchronous reset mid-transaction
    do_reset();
    drive(2'b01, 4'b0000, 1'b0, 2'b00);
    drive(2'b01, 4'b1000, 1'b0, 2'b00);
    chk("t5_foreign_core_in", int'(core_in), 0);
    chk("t5_gnt", int'(gnt), 1);
    drive(2'b01, 4'b0110, 1'b0, 2'b00);
    chk("t5_own_core_in", int'(core_in), 2);
    drive(2'b01, 4'b0100, 1'b0, 2'b00);
    chk("t5_busy", int'(busy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_gnt", int'(gnt), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_core_in", int'(core_in), 0);
    chk("t5_rst_refund", int'(refund), 0);
    chk("t5_rst_done", int'(done), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; coin = '0;
    drive(2'b01, 4'b0000, 1'b0, 2'b00);
    drive(2'b01, 4'b0001, 1'b0, 2'b00);
    drive(2'b01, 4'b0010, 1'b0, 2'b00);
    drive(2'b01, 4'b0000, 1'b1, 2'b01);
    chk("t5_new_txn_done", int'(done), 1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r;
      logic [2*N-1:0] c;
      r = ($urandom_range(0, 7) == 0) ? N'($urandom) : req;
      c = ($urandom_range(0, 2) == 0) ? (2*N)'($urandom) : '0;
      drive(r, c, $urandom_range(0, 9) == 0, 2'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
